// File: rtl/issue_sched_if.sv
// rtl/issue_sched_if.sv - issue-queue head and FU-side bundle for issue_sched.
interface issue_sched_if #(
  parameter int ISSUE_W   = 2,
  parameter int PIPE_D    = 3,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 64
);
  localparam int CW = $clog2(ISSUE_W + 1);

  logic [CW-1:0]               iq_size;
  logic [2*ISSUE_W-1:0]        iq_src_need;
  logic [2*ISSUE_W*5-1:0]      iq_src_addr;
  logic [2*ISSUE_W*DATA_W-1:0] iq_imm;
  logic [ISSUE_W-1:0]          iq_wr_need;
  logic [ISSUE_W*5-1:0]        iq_wr_addr;
  logic [ISSUE_W*PIPE_D-1:0]   iq_accept_mask;
  logic [ISSUE_W-1:0]          iq_is_branch;
  logic [ISSUE_W*PAYLOAD_W-1:0] iq_payload;
  logic [CW-1:0]               iq_pop_number;

  logic [ISSUE_W-1:0]           fu_valid;
  logic [ISSUE_W*DATA_W-1:0]    fu_num1;
  logic [ISSUE_W*DATA_W-1:0]    fu_num2;
  logic [ISSUE_W-1:0]           fu_wr_need;
  logic [ISSUE_W*5-1:0]         fu_wr_addr;
  logic [ISSUE_W*PAYLOAD_W-1:0] fu_payload;

  modport master (
    output iq_size, iq_src_need, iq_src_addr, iq_imm, iq_wr_need, iq_wr_addr,
           iq_accept_mask, iq_is_branch, iq_payload,
    input  iq_pop_number, fu_valid, fu_num1, fu_num2, fu_wr_need, fu_wr_addr, fu_payload
  );

  modport slave (
    input  iq_size, iq_src_need, iq_src_addr, iq_imm, iq_wr_need, iq_wr_addr,
           iq_accept_mask, iq_is_branch, iq_payload,
    output iq_pop_number, fu_valid, fu_num1, fu_num2, fu_wr_need, fu_wr_addr, fu_payload
  );
endinterface

// File: rtl/issue_sched.sv
// rtl/issue_sched.sv - in-order N-way issue stage with scoreboard and registered FU boundary.
// Defining ISSUE_PERF_EN adds perf_stall_cnt / perf_issue_cnt outputs.
module issue_sched #(
  parameter int ISSUE_W   = 2,
  parameter int PIPE_D    = 3,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flash,
  input  logic                          stall,
  issue_sched_if.slave                  q,
  output logic [2*ISSUE_W*5-1:0]        regfile_read_addr,
  input  logic [2*ISSUE_W*DATA_W-1:0]   regfile_read_data,
  output logic [2*ISSUE_W*PIPE_D-1:0]   sb_position,
  output logic [2*ISSUE_W*((ISSUE_W > 1) ? $clog2(ISSUE_W) : 1)-1:0] sb_line,
  input  logic [2*ISSUE_W*DATA_W-1:0]   bypass_result
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt,
  output logic [31:0]                   perf_issue_cnt
`endif
);
  localparam int CW = $clog2(ISSUE_W + 1);
  localparam int LW = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int NS = 2 * ISSUE_W;
  localparam logic [PIPE_D-1:0] POS_TOP = PIPE_D'(1) << (PIPE_D - 1);

  logic [PIPE_D-1:0] pos_q [32];
  logic [PIPE_D-1:0] pos_d [32];
  logic [PIPE_D-1:0] mask_q [32];
  logic [PIPE_D-1:0] mask_d [32];
  logic [LW-1:0]     line_q [32];
  logic [LW-1:0]     line_d [32];

  logic [ISSUE_W-1:0]           fu_valid_q, fu_valid_d;
  logic [ISSUE_W*DATA_W-1:0]    fu_num1_q, fu_num1_d;
  logic [ISSUE_W*DATA_W-1:0]    fu_num2_q, fu_num2_d;
  logic [ISSUE_W-1:0]           fu_wr_need_q, fu_wr_need_d;
  logic [ISSUE_W*5-1:0]         fu_wr_addr_q, fu_wr_addr_d;
  logic [ISSUE_W*PAYLOAD_W-1:0] fu_payload_q, fu_payload_d;

  logic [NS-1:0]     src_rdy;
  logic [DATA_W-1:0] src_val [NS];
  logic [ISSUE_W-1:0] iss;
  logic [CW-1:0]      pop;

  assign regfile_read_addr = q.iq_src_addr;
  assign q.iq_pop_number   = pop;
  assign q.fu_valid        = fu_valid_q;
  assign q.fu_num1         = fu_num1_q;
  assign q.fu_num2         = fu_num2_q;
  assign q.fu_wr_need      = fu_wr_need_q;
  assign q.fu_wr_addr      = fu_wr_addr_q;
  assign q.fu_payload      = fu_payload_q;

  // Operand readiness; a source produced earlier in the same bundle is never forwarded.
  always_comb begin
    logic [4:0] a;
    logic       haz;
    sb_position = '0;
    sb_line     = '0;
    for (int s = 0; s < NS; s++) begin
      a          = q.iq_src_addr[s*5 +: 5];
      src_rdy[s] = 1'b0;
      src_val[s] = '0;
      sb_position[s*PIPE_D +: PIPE_D] = pos_q[a];
      sb_line[s*LW +: LW]             = line_q[a];
      haz = 1'b0;
      for (int m = 0; m < ISSUE_W; m++) begin
        if (m < (s >> 1) && q.iq_wr_need[m] && q.iq_wr_addr[m*5 +: 5] == a && a != 5'd0)
          haz = 1'b1;
      end
      if (!q.iq_src_need[s]) begin
        src_rdy[s] = 1'b1;
        src_val[s] = q.iq_imm[s*DATA_W +: DATA_W];
      end else if (haz) begin
        src_rdy[s] = 1'b0;
      end else if (pos_q[a] == '0) begin
        src_rdy[s] = 1'b1;
        src_val[s] = regfile_read_data[s*DATA_W +: DATA_W];
      end else if ((pos_q[a] & mask_q[a]) != '0) begin
        src_rdy[s] = 1'b1;
        src_val[s] = bypass_result[s*DATA_W +: DATA_W];
      end
    end
  end

  // Ready prefix first, then trim from the top so a branch never leaves without its delay slot.
  always_comb begin
    logic [ISSUE_W-1:0] pre;
    logic run;
    logic nxt;
    pre = '0;
    iss = '0;
    pop = '0;
    run = 1'b1;
    for (int k = 0; k < ISSUE_W; k++) begin
      run    = run && (CW'(k) < q.iq_size) && src_rdy[2*k] && src_rdy[2*k+1];
      pre[k] = run;
    end
    nxt = 1'b0;
    for (int k = ISSUE_W - 1; k >= 0; k--) begin
      iss[k] = pre[k] && (!q.iq_is_branch[k] || nxt);
      nxt    = iss[k];
    end
    if (stall || flash)
      iss = '0;
    for (int k = 0; k < ISSUE_W; k++)
      pop = pop + CW'(iss[k]);
  end

  always_comb begin
    for (int e = 0; e < 32; e++) begin
      pos_d[e]  = pos_q[e];
      mask_d[e] = mask_q[e];
      line_d[e] = line_q[e];
    end
    if (flash) begin
      for (int e = 0; e < 32; e++)
        pos_d[e] = '0;
    end else if (!stall) begin
      for (int e = 0; e < 32; e++)
        pos_d[e] = pos_q[e] >> 1;
      // Ascending slot order lets the younger writer of a shared destination win.
      for (int k = 0; k < ISSUE_W; k++) begin
        if (iss[k] && q.iq_wr_need[k] && q.iq_wr_addr[k*5 +: 5] != 5'd0) begin
          pos_d[q.iq_wr_addr[k*5 +: 5]]  = POS_TOP;
          line_d[q.iq_wr_addr[k*5 +: 5]] = LW'(k);
          mask_d[q.iq_wr_addr[k*5 +: 5]] = q.iq_accept_mask[k*PIPE_D +: PIPE_D];
        end
      end
    end
  end

  always_comb begin
    fu_valid_d   = fu_valid_q;
    fu_num1_d    = fu_num1_q;
    fu_num2_d    = fu_num2_q;
    fu_wr_need_d = fu_wr_need_q;
    fu_wr_addr_d = fu_wr_addr_q;
    fu_payload_d = fu_payload_q;
    if (flash) begin
      fu_valid_d   = '0;
      fu_num1_d    = '0;
      fu_num2_d    = '0;
      fu_wr_need_d = '0;
      fu_wr_addr_d = '0;
      fu_payload_d = '0;
    end else if (!stall) begin
      for (int k = 0; k < ISSUE_W; k++) begin
        fu_valid_d[k]   = iss[k];
        fu_wr_need_d[k] = iss[k] & q.iq_wr_need[k];
        fu_wr_addr_d[k*5 +: 5]           = iss[k] ? q.iq_wr_addr[k*5 +: 5] : 5'd0;
        fu_num1_d[k*DATA_W +: DATA_W]    = iss[k] ? src_val[2*k] : '0;
        fu_num2_d[k*DATA_W +: DATA_W]    = iss[k] ? src_val[2*k+1] : '0;
        fu_payload_d[k*PAYLOAD_W +: PAYLOAD_W] =
          iss[k] ? q.iq_payload[k*PAYLOAD_W +: PAYLOAD_W] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < 32; e++) begin
        pos_q[e]  <= '0;
        mask_q[e] <= '0;
        line_q[e] <= '0;
      end
      fu_valid_q   <= '0;
      fu_num1_q    <= '0;
      fu_num2_q    <= '0;
      fu_wr_need_q <= '0;
      fu_wr_addr_q <= '0;
      fu_payload_q <= '0;
    end else begin
      for (int e = 0; e < 32; e++) begin
        pos_q[e]  <= pos_d[e];
        mask_q[e] <= mask_d[e];
        line_q[e] <= line_d[e];
      end
      fu_valid_q   <= fu_valid_d;
      fu_num1_q    <= fu_num1_d;
      fu_num2_q    <= fu_num2_d;
      fu_wr_need_q <= fu_wr_need_d;
      fu_wr_addr_q <= fu_wr_addr_d;
      fu_payload_q <= fu_payload_d;
    end
  end

`ifdef ISSUE_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_issue_q, perf_issue_d;

  always_comb begin
    perf_stall_d = perf_stall_q +
                   ((q.iq_size != '0 && !stall && !flash && pop == '0) ? 32'd1 : 32'd0);
    perf_issue_d = perf_issue_q + 32'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_issue_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_issue_q <= perf_issue_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_issue_cnt = perf_issue_q;
`endif
endmodule

// File: tb/tb_issue_sched.sv
// tb/tb_issue_sched.sv - directed vector bench for issue_sched (2 slots, 3 stages).
module tb_issue_sched;
  localparam logic [31:0] I0 = 32'hC0DE_0000, I1 = 32'hC0DE_0001;
  localparam logic [31:0] I2 = 32'hC0DE_0002, I3 = 32'hC0DE_0003;
  localparam logic [31:0] R3 = 32'hA000_0003, R4 = 32'hA000_0004;
  localparam logic [31:0] R5 = 32'hA000_0005, R9 = 32'hA000_0009;
  localparam logic [31:0] B0 = 32'hB000_0000, Z  = 32'h0;
  localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF, P1 = 64'hFEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flash = 1'b0;
  logic stall = 1'b0;
  logic [19:0]  rf_addr;
  logic [127:0] rf_data;
  logic [11:0]  sbp;
  logic [3:0]   sbl;
  logic [127:0] byp;
`ifdef ISSUE_PERF_EN
  logic [31:0] perf_stall_cnt, perf_issue_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  issue_sched_if #(.ISSUE_W(2), .PIPE_D(3), .DATA_W(32), .PAYLOAD_W(64)) q ();

  issue_sched #(.ISSUE_W(2), .PIPE_D(3), .DATA_W(32), .PAYLOAD_W(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flash             (flash),
    .stall             (stall),
    .q                 (q),
    .regfile_read_addr (rf_addr),
    .regfile_read_data (rf_data),
    .sb_position       (sbp),
    .sb_line           (sbl),
    .bypass_result     (byp)
`ifdef ISSUE_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_issue_cnt    (perf_issue_cnt)
`endif
  );

  always_comb begin
    rf_data = '0;
    for (int s = 0; s < 4; s++)
      rf_data[s*32 +: 32] = 32'hA000_0000 | {27'd0, rf_addr[s*5 +: 5]};
  end
  assign byp = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};

  typedef struct {
    logic [1:0]  size;
    logic [3:0]  need;
    logic [19:0] sa;
    logic [1:0]  wrn;
    logic [9:0]  wra;
    logic [5:0]  mask;
    logic [1:0]  br;
    logic        st;
    logic        fl;
    logic [1:0]  pop;
    logic [11:0] sbp;
    logic [3:0]  ln;
    logic [1:0]  v;
    logic [63:0] n1;
    logic [63:0] n2;
  } vec_t;

  vec_t tv [22];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    q.iq_size        = t.size;
    q.iq_src_need    = t.need;
    q.iq_src_addr    = t.sa;
    q.iq_wr_need     = t.wrn;
    q.iq_wr_addr     = t.wra;
    q.iq_accept_mask = t.mask;
    q.iq_is_branch   = t.br;
    stall            = t.st;
    flash            = t.fl;
  endtask

  task automatic idle();
    q.iq_size = '0; q.iq_src_need = '0; q.iq_src_addr = '0; q.iq_wr_need = '0;
    q.iq_wr_addr = '0; q.iq_accept_mask = '0; q.iq_is_branch = '0;
    stall = 1'b0; flash = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_pl;
    tv[0]  = '{2'd2, 4'b0000, 20'h00000, 2'b00, 10'd0, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd2, 12'h000, 4'h0, 2'b11, {I2, I0}, {I3, I1}};
    tv[1]  = '{2'd2, 4'b0100, 20'h01400, 2'b01, 10'd5, 6'b000001, 2'b00, 1'b0, 1'b0, 2'd1, 12'h000, 4'h0, 2'b01, {Z, I0}, {Z, I1}};
    tv[2]  = '{2'd1, 4'b0001, 20'h00005, 2'b00, 10'd0, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd0, 12'h004, 4'h0, 2'b00, {Z, Z}, {Z, Z}};
    tv[3]  = '{2'd1, 4'b0001, 20'h00005, 2'b00, 10'd0, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd0, 12'h002, 4'h0, 2'b00, {Z, Z}, {Z, Z}};
    tv[4]  = '{2'd1, 4'b0001, 20'h00005, 2'b00, 10'd0, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd1, 12'h001, 4'h0, 2'b01, {Z, B0}, {Z, I1}};
    tv[5]  = '{2'd2, 4'b0101, 20'h01405, 2'b00, 10'd0, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd2, 12'h000, 4'h0, 2'b11, {R5, R5}, {I3, I1}};
    tv[6]  = '{2'd1, 4'b0000, 20'h00000, 2'b01, 10'd9, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd1, 12'h000, 4'h0, 2'b01, {Z, I0}, {Z, I1}};
    tv[7]  = '{2'd2, 4'b0100, 20'h02400, 2'b00, 10'd0, 6'b000000, 2'b01, 1'b0, 1'b0, 2'd0, 12'h100, 4'h0, 2'b00, {Z, Z}, {Z, Z}};
    tv[8]  = '{2'd2, 4'b0100, 20'h02400, 2'b00, 10'd0, 6'b000000, 2'b01, 1'b0, 1'b0, 2'd0, 12'h080, 4'h0, 2'b00, {Z, Z}, {Z, Z}};
    tv[9]  = '{2'd2, 4'b0100, 20'h02400, 2'b00, 10'd0, 6'b000000, 2'b01, 1'b0, 1'b0, 2'd0, 12'h040, 4'h0, 2'b00, {Z, Z}, {Z, Z}};
    tv[10] = '{2'd2, 4'b0100, 20'h02400, 2'b00, 10'd0, 6'b000000, 2'b01, 1'b0, 1'b0, 2'd2, 12'h000, 4'h0, 2'b11, {R9, I0}, {I3, I1}};
    tv[11] = '{2'd1, 4'b0000, 20'h00000, 2'b00, 10'd0, 6'b000000, 2'b01, 1'b0, 1'b0, 2'd0, 12'h000, 4'h0, 2'b00, {Z, Z}, {Z, Z}};
    tv[12] = '{2'd2, 4'b0000, 20'h00000, 2'b00, 10'd0, 6'b000000, 2'b10, 1'b0, 1'b0, 2'd1, 12'h000, 4'h0, 2'b01, {Z, I0}, {Z, I1}};
    tv[13] = '{2'd2, 4'b0000, 20'h00000, 2'b11, 10'h0E7, 6'b000111, 2'b00, 1'b0, 1'b0, 2'd2, 12'h000, 4'h0, 2'b11, {I2, I0}, {I3, I1}};
    tv[14] = '{2'd1, 4'b0001, 20'h00007, 2'b00, 10'd0, 6'b000000, 2'b00, 1'b1, 1'b0, 2'd0, 12'h004, 4'h1, 2'b11, {I2, I0}, {I3, I1}};
    tv[15] = tv[14];
    tv[16] = tv[14];
    tv[17] = '{2'd1, 4'b0001, 20'h00007, 2'b00, 10'd0, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd0, 12'h004, 4'h1, 2'b00, {Z, Z}, {Z, Z}};
    tv[18] = '{2'd1, 4'b0000, 20'h00000, 2'b01, 10'd3, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd1, 12'h000, 4'h0, 2'b01, {Z, I0}, {Z, I1}};
    tv[19] = '{2'd1, 4'b0000, 20'h00000, 2'b01, 10'd4, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd1, 12'h000, 4'h0, 2'b01, {Z, I0}, {Z, I1}};
    tv[20] = '{2'd2, 4'b0011, 20'h00083, 2'b00, 10'd0, 6'b000000, 2'b00, 1'b0, 1'b1, 2'd0, 12'h022, 4'h0, 2'b00, {Z, Z}, {Z, Z}};
    tv[21] = '{2'd2, 4'b0011, 20'h00083, 2'b00, 10'd0, 6'b000000, 2'b00, 1'b0, 1'b0, 2'd2, 12'h000, 4'h0, 2'b11, {I2, R3}, {I3, R4}};

    q.iq_imm     = {I3, I2, I1, I0};
    q.iq_payload = {P1, P0};
    idle();
    repeat (3) @(negedge clk);
    chk("rst fu_valid", 128'(q.fu_valid), 128'(2'b00));
    chk("rst fu_num1", 128'(q.fu_num1), 128'(0));
    chk("rst fu_num2", 128'(q.fu_num2), 128'(0));
    chk("rst fu_payload", 128'(q.fu_payload), 128'(0));
    chk("rst sb_position", 128'(sbp), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tv[i]);
      #2;
      chk($sformatf("v%0d pop", i), 128'(q.iq_pop_number), 128'(tv[i].pop));
      chk($sformatf("v%0d sb_position", i), 128'(sbp), 128'(tv[i].sbp));
      chk($sformatf("v%0d sb_line", i), 128'(sbl), 128'(tv[i].ln));
      @(posedge clk);
      #1;
      exp_pl = {64'd0, (tv[i].v[1] ? P1 : 64'd0), (tv[i].v[0] ? P0 : 64'd0)};
      chk($sformatf("v%0d fu_valid", i), 128'(q.fu_valid), 128'(tv[i].v));
      chk($sformatf("v%0d fu_num1", i), 128'(q.fu_num1), 128'(tv[i].n1));
      chk($sformatf("v%0d fu_num2", i), 128'(q.fu_num2), 128'(tv[i].n2));
      chk($sformatf("v%0d fu_payload", i), 128'(q.fu_payload), exp_pl);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a cycle with r6 pending and a bundle in flight.
    idle();
    q.iq_size = 2'd1; q.iq_wr_need = 2'b01; q.iq_wr_addr = 10'd6;
    @(posedge clk);
    #1;
    chk("mid fu_valid before", 128'(q.fu_valid), 128'(2'b01));
    q.iq_wr_need = 2'b00; q.iq_wr_addr = 10'd0;
    q.iq_src_need = 4'b0001; q.iq_src_addr = 20'h00006;
    #1;
    chk("mid sb_position before", 128'(sbp), 128'(12'h004));
    rst_n = 1'b0;
    #1;
    chk("mid fu_valid", 128'(q.fu_valid), 128'(2'b00));
    chk("mid fu_num1", 128'(q.fu_num1), 128'(0));
    chk("mid fu_payload", 128'(q.fu_payload), 128'(0));
    chk("mid sb_position", 128'(sbp), 128'(0));
    @(negedge clk);
    idle();
    rst_n = 1'b1;

`ifdef ISSUE_PERF_EN
    for (int i = 0; i < 4; i++) begin
      idle();
      q.iq_size = 2'd1; q.iq_is_branch = 2'b01;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      q.iq_size = 2'd2;
      @(negedge clk);
    end
    idle();
    #1;
    chk("perf_stall_cnt", 128'(perf_stall_cnt), 128'(32'd4));
    chk("perf_issue_cnt", 128'(perf_issue_cnt), 128'(32'd6));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
